// File: rtl/lsu.sv
// lsu: RV32 load/store unit; op strobe in (start, addr, wdata, is_*), single-beat bus master out (mem_*), result out (done, load_data, misaligned, access_fault)
module lsu #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        is_lb,
  input  logic        is_lh,
  input  logic        is_lw,
  input  logic        is_lbu,
  input  logic        is_lhu,
  input  logic        is_sb,
  input  logic        is_sh,
  input  logic        is_sw,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        access_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t st, nxt;
  logic [31:0] addr_q, wdata_q, ext;
  logic store_q, byte_q, half_q, sgn_q, acc, mis, tmo;
  logic [7:0] cnt, b;
  logic [15:0] h;
  assign acc = st == IDLE && start && $onehot({is_lb, is_lh, is_lw, is_lbu, is_lhu, is_sb, is_sh, is_sw});
  assign mis = ((is_lh | is_lhu | is_sh) & addr[0]) | ((is_lw | is_sw) & |addr[1:0]);
  assign tmo = cnt == 8'(MAX_WAIT - 1);
  always_comb begin
    nxt = st;
    case (st)
      IDLE: nxt = acc ? (mis ? RESP : REQ) : IDLE;
      REQ: nxt = mem_gnt ? (store_q ? RESP : WAIT) : tmo ? RESP : REQ;
      WAIT: nxt = (mem_rvalid || tmo) ? RESP : WAIT;
      default: nxt = IDLE;
    endcase
  end
  assign busy = st != IDLE;
  assign done = st == RESP;
  assign mem_req = st == REQ;
  assign mem_we = mem_req & store_q;
  assign mem_addr = mem_req ? {addr_q[31:2], 2'b00} : '0;
  assign mem_be = !mem_req ? 4'b0000 : byte_q ? 4'b0001 << addr_q[1:0] : half_q ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign mem_wdata = !mem_we ? '0 : byte_q ? {4{wdata_q[7:0]}} : half_q ? {2{wdata_q[15:0]}} : wdata_q;
  assign b = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign h = mem_rdata[{addr_q[1], 4'b0000} +: 16];
  assign ext = byte_q ? {{24{sgn_q & b[7]}}, b} : half_q ? {{16{sgn_q & h[15]}}, h} : mem_rdata;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      store_q <= 1'b0;
      byte_q <= 1'b0;
      half_q <= 1'b0;
      sgn_q <= 1'b0;
      load_data <= '0;
      misaligned <= 1'b0;
      access_fault <= 1'b0;
    end else begin
      st <= nxt;
      // cycles spent in REQ/WAIT; restarts on every state change
      cnt <= (nxt == st && (st == REQ || st == WAIT)) ? cnt + 8'd1 : '0;
      if (acc) begin
        addr_q <= addr;
        wdata_q <= wdata;
        store_q <= is_sb | is_sh | is_sw;
        byte_q <= is_lb | is_lbu | is_sb;
        half_q <= is_lh | is_lhu | is_sh;
        sgn_q <= is_lb | is_lh;
      end
      // result registers only change on the way into RESP, so they hold between completions
      if (nxt == RESP && st != RESP) begin
        load_data <= (st == WAIT && mem_rvalid) ? ext : '0;
        misaligned <= st == IDLE;
        access_fault <= (st == REQ && !mem_gnt) || (st == WAIT && !mem_rvalid);
      end
    end
  end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: randomized check of lsu against a transaction-level reference model
module tb_lsu;
  localparam int MW = 6;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
  logic is_lb, is_lh, is_lw, is_lbu, is_lhu, is_sb, is_sh, is_sw;
  logic busy, done, misaligned, access_fault, mem_req, mem_we;
  logic mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0] mem_be;
  int n_run = 0, n_fail = 0;
  lsu #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .wdata(wdata),
    .is_lb(is_lb), .is_lh(is_lh), .is_lw(is_lw), .is_lbu(is_lbu), .is_lhu(is_lhu),
    .is_sb(is_sb), .is_sh(is_sh), .is_sw(is_sw),
    .busy(busy), .done(done), .load_data(load_data), .misaligned(misaligned), .access_fault(access_fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic set_ops(input logic [7:0] f);
    {is_lb, is_lh, is_lw, is_lbu, is_lhu, is_sb, is_sh, is_sw} = f;
  endtask
  // op: 0 lb 1 lh 2 lw 3 lbu 4 lhu 5 sb 6 sh 7 sw; gd = REQ cycles before grant, rdd = WAIT cycles before rvalid
  task automatic run(input int op, input logic [31:0] a, input logic [31:0] w, input logic [31:0] rd, input int gd, input int rdd);
    logic byt, hlf, wrd, st, sg, mis, gflt, wflt, gnted;
    logic [1:0] k;
    logic [31:0] ebe, ewd, eld, bv, hv;
    int edone, ereq, r, wc, dc;
    byt = op == 0 || op == 3 || op == 5;
    hlf = op == 1 || op == 4 || op == 6;
    wrd = op == 2 || op == 7;
    st = op >= 5;
    sg = op <= 1;
    k = a[1:0];
    mis = (hlf && a[0]) || (wrd && k != 0);
    gflt = !mis && gd >= MW;
    wflt = !mis && !st && !gflt && rdd >= MW;
    ebe = byt ? 32'd1 << k : hlf ? (a[1] ? 32'd12 : 32'd3) : 32'd15;
    ewd = !st ? 32'd0 : byt ? 32'(w[7:0]) * 32'h01010101 : hlf ? 32'(w[15:0]) * 32'h00010001 : w;
    bv = (rd >> (8 * k)) & 32'hFF;
    hv = (rd >> (16 * a[1])) & 32'hFFFF;
    eld = (mis || st || gflt || wflt) ? 32'd0 : byt ? ((sg && bv >= 128) ? bv - 32'd256 : bv) :
          hlf ? ((sg && hv >= 32768) ? hv - 32'd65536 : hv) : rd;
    edone = mis ? 1 : gflt ? MW + 1 : st ? gd + 2 : wflt ? gd + 2 + MW : gd + 3 + rdd;
    ereq = mis ? 0 : gflt ? MW : gd + 1;
    @(negedge clk);
    start = 1'b1;
    set_ops(8'h80 >> op);
    addr = a;
    wdata = w;
    r = 0;
    wc = 0;
    dc = 0;
    gnted = 1'b0;
    for (int c = 1; c <= 2 * MW + 12 && dc == 0; c++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      set_ops(8'h80 >> $urandom_range(0, 7));
      addr = $urandom;
      wdata = $urandom;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata = $urandom;
      if (done) dc = c;
      else if (mem_req) begin
        chk("mem_addr", mem_addr, a & ~32'd3);
        chk("mem_be", 32'(mem_be), ebe);
        chk("mem_wdata", mem_wdata, ewd);
        chk("mem_we", 32'(mem_we), 32'(st));
        mem_rvalid = 1'($urandom_range(0, 1));
        if (r == gd) begin
          mem_gnt = 1'b1;
          gnted = 1'b1;
        end
        r++;
      end else if (gnted) begin
        if (wc == rdd) begin
          mem_rvalid = 1'b1;
          mem_rdata = rd;
        end
        wc++;
      end
    end
    chk("done_lat", dc, edone);
    chk("req_cycles", r, ereq);
    chk("load_data", load_data, eld);
    chk("misaligned", 32'(misaligned), 32'(mis));
    chk("access_fault", 32'(access_fault), 32'(gflt || wflt));
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    start = 1'b0;
    set_ops(8'h00);
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("late_rvalid_busy", 32'(busy | done), 32'd0);
    chk("load_hold", load_data, eld);
  endtask
  task automatic bad_start(input logic multi);
    int i;
    i = $urandom_range(0, 7);
    @(negedge clk);
    start = 1'b1;
    addr = $urandom & ~32'd3;
    set_ops(multi ? (8'h80 >> i) | (8'h80 >> ((i + 1 + $urandom_range(0, 6)) % 8)) : 8'h00);
    @(negedge clk);
    start = 1'b0;
    set_ops(8'h00);
    chk("bad_start", 32'(busy | mem_req), 32'd0);
  endtask
  initial begin
    set_ops(8'h00);
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy | done | mem_req | mem_we), 32'd0);
    chk("rst_outs", load_data | mem_addr | mem_wdata | 32'(mem_be), 32'd0);
    rst_n = 1'b1;
    run(0, 32'h1003, 32'h0, 32'h80FF1234, 0, 0);
    run(6, 32'h2002, 32'hDEADBEEF, 32'h0, 3, 0);
    run(2, 32'h3001, 32'h0, 32'h0, 0, 0);
    run(4, 32'h4002, 32'h0, 32'h80010000, MW, 0);
    run(4, 32'h4002, 32'h0, 32'h80010000, 0, MW);
    run(4, 32'h4002, 32'h0, 32'h80010000, MW - 1, MW - 1);
    bad_start(1'b0);
    bad_start(1'b1);
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 9) == 0) bad_start(1'($urandom_range(0, 1)));
      run($urandom_range(0, 7), $urandom, $urandom, $urandom, $urandom_range(0, MW + 1), $urandom_range(0, MW + 1));
    end
    run(2, 32'h40, 32'h0, 32'h12345678, 0, 0);
    @(negedge clk);
    start = 1'b1;
    set_ops(8'h20);
    addr = 32'h20;
    @(negedge clk);
    start = 1'b0;
    set_ops(8'h00);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(busy | done | mem_req | misaligned | access_fault), 32'd0);
    chk("async_rst_data", load_data | mem_addr | 32'(mem_be), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("post_rst_rvalid", 32'(done | busy | mem_req), 32'd0);
    run(7, 32'h10, 32'hCAFEF00D, 32'h0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
